alg_issue_ctrl: RTL and testbench

Issue/writeback controller for the extended-arithmetic (ALG) unit in the LC-3b pipeline. It sits in EX, directly upstream and downstream of the ALG unit. It accepts an extended op from the EX stage, latches and holds operands and opcode stable while stalling the pipeline, and waits for the unit's `done`. It then writes the 32-bit product back to two consecutive registers (lo, then hi) and keeps architectural `hi_reg`/`lo_reg` copies. It also handles flush and drain, illegal ops, and a watchdog timeout.

---
 rtl/alg_issue_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_alg_issue_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alg_issue_ctrl.sv
// Issue/writeback controller for the extended-arithmetic (ALG) unit.
// Captures a multiply from EX, holds operands stable for the unit while the
// pipeline is stalled, then writes the 32-bit product back as lo/hi into two
// consecutive registers. Handles flush/drain, illegal ops and a watchdog.
module alg_issue_ctrl #(
   parameter logic [2:0] OP_NOP   = 3'b000,
   parameter int         MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic [2:0]  issue_op,
   input  logic [15:0] issue_a,
   input  logic [15:0] issue_b,
   input  logic [2:0]  issue_dest,
   input  logic        flush,
   output logic        stall,
   output logic [2:0]  alg_op,
   output logic [15:0] alg_opA,
   output logic [15:0] alg_opB,
   input  logic        alg_done,
   input  logic [15:0] alg_hi,
   input  logic [15:0] alg_lo,
   output logic        wb_valid,
   output logic [2:0]  wb_dest,
   output logic [15:0] wb_data,
   output logic [15:0] hi_reg,
   output logic [15:0] lo_reg,
   output logic        illegal_op,
   output logic        err_timeout
);

   // op_x_bits encoding of the multiply in lc3b_types
   localparam logic [2:0] OP_MUL    = 3'b001;
   // last watchdog count before expiry: the wait lasts MAX_WAIT cycles
   localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BUSY,
      S_WB_LO,
      S_WB_HI,
      S_DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  alg_op_q, alg_op_d;
   logic [15:0] opa_q, opa_d;
   logic [15:0] opb_q, opb_d;
   logic [2:0]  dest_q, dest_d;
   logic [15:0] hi_q, hi_d;
   logic [15:0] lo_q, lo_d;
   logic        ill_q, ill_d;
   logic        tmo_q, tmo_d;
   logic [3:0]  wcnt_q, wcnt_d;

   logic        is_mul;
   logic        accept;

   assign is_mul = (issue_op == OP_MUL);
   assign accept = issue_valid && !flush && is_mul;

   // Next-state, datapath capture and combinational stall/writeback decode
   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      dest_d   = dest_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      ill_d    = 1'b0;
      tmo_d    = 1'b0;
      wcnt_d   = wcnt_q;
      stall    = 1'b0;
      wb_valid = 1'b0;
      wb_dest  = 3'd0;
      wb_data  = 16'd0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               stall   = 1'b1;
               state_d = S_BUSY;
               opa_d   = issue_a;
               opb_d   = issue_b;
               dest_d  = issue_dest;
               wcnt_d  = 4'd0;
            end else if (issue_valid && !flush) begin
               ill_d = 1'b1;
            end
         end

         S_BUSY: begin
            stall = 1'b1;
            if (flush) begin
               // done in the same cycle as flush: the unit is already back at
               // its reload value, so there is nothing left to drain
               state_d = alg_done ? S_IDLE : S_DRAIN;
               wcnt_d  = 4'd0;
            end else if (alg_done) begin
               hi_d    = alg_hi;
               lo_d    = alg_lo;
               state_d = S_WB_LO;
            end else if (wcnt_q == WAIT_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end

         S_DRAIN: begin
            // only hold the pipeline if a new multiply is waiting behind us
            stall = issue_valid && is_mul;
            if (alg_done) begin
               state_d = S_IDLE;
            end else if (wcnt_q == WAIT_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end

         S_WB_LO: begin
            stall    = 1'b1;
            wb_valid = 1'b1;
            wb_dest  = dest_q;
            wb_data  = lo_q;
            state_d  = S_WB_HI;
         end

         S_WB_HI: begin
            stall    = 1'b1;
            wb_valid = 1'b1;
            wb_dest  = dest_q + 3'd1;
            wb_data  = hi_q;
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // the unit sees the multiply exactly while we wait on it (busy or drain)
      alg_op_d = ((state_d == S_BUSY) || (state_d == S_DRAIN)) ? OP_MUL : OP_NOP;
   end

   // State and registered outputs; reset abandons any in-flight operation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         alg_op_q <= OP_NOP;
         opa_q    <= 16'd0;
         opb_q    <= 16'd0;
         dest_q   <= 3'd0;
         hi_q     <= 16'd0;
         lo_q     <= 16'd0;
         ill_q    <= 1'b0;
         tmo_q    <= 1'b0;
         wcnt_q   <= 4'd0;
      end else begin
         state_q  <= state_d;
         alg_op_q <= alg_op_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         dest_q   <= dest_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         ill_q    <= ill_d;
         tmo_q    <= tmo_d;
         wcnt_q   <= wcnt_d;
      end
   end

   assign alg_op      = alg_op_q;
   assign alg_opA     = opa_q;
   assign alg_opB     = opb_q;
   assign hi_reg      = hi_q;
   assign lo_reg      = lo_q;
   assign illegal_op  = ill_q;
   assign err_timeout = tmo_q;

endmodule

// File: tb/tb_alg_issue_ctrl.sv
// Bench for alg_issue_ctrl: a bench-side ALG unit, a transaction-level model
// of the controller, directed scenarios and a randomized run.
module tb_alg_issue_ctrl;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_MUL   = 3'b001;
   localparam int         MAX_WAIT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [2:0]  issue_op;
   logic [15:0] issue_a, issue_b;
   logic [2:0]  issue_dest;
   logic        flush;
   logic        stall;
   logic [2:0]  alg_op;
   logic [15:0] alg_opA, alg_opB;
   logic        alg_done;
   logic [15:0] alg_hi, alg_lo;
   logic        wb_valid;
   logic [2:0]  wb_dest;
   logic [15:0] wb_data;
   logic [15:0] hi_reg, lo_reg;
   logic        illegal_op, err_timeout;

   always #5 clk = ~clk;

   alg_issue_ctrl #(.OP_NOP(OP_NOP), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_a(issue_a), .issue_b(issue_b), .issue_dest(issue_dest),
      .flush(flush), .stall(stall),
      .alg_op(alg_op), .alg_opA(alg_opA), .alg_opB(alg_opB),
      .alg_done(alg_done), .alg_hi(alg_hi), .alg_lo(alg_lo),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
      .hi_reg(hi_reg), .lo_reg(lo_reg),
      .illegal_op(illegal_op), .err_timeout(err_timeout)
   );

   int checks = 0;
   int errors = 0;

   // transaction-level model: an op is either waiting on the unit (possibly
   // cancelled) or has some number of register writes still to make
   bit          m_inflight, m_cancel, m_ill, m_tmo;
   int          m_wait, m_wb;
   logic [2:0]  m_dest, m_aop;
   logic [15:0] m_a, m_b, m_hi, m_lo;

   // bench-side ALG unit: done after ulat consecutive multiply cycles
   int ucnt, ulat;
   bit uhold, urand;

   // per-scenario observations
   int          n_stall, n_ill, n_tmo;
   logic [2:0]  log_dest[$];
   logic [15:0] log_data[$];
   bit          retire;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_inflight = 0; m_cancel = 0; m_ill = 0; m_tmo = 0;
      m_wait = 0; m_wb = 0;
      m_dest = 3'd0; m_aop = OP_NOP;
      m_a = 16'd0; m_b = 16'd0; m_hi = 16'd0; m_lo = 16'd0;
      ucnt = 0; ulat = 4; uhold = 0;
   endtask

   task automatic clear_obs();
      n_stall = 0; n_ill = 0; n_tmo = 0;
      log_dest.delete(); log_data.delete();
   endtask

   task automatic check_reset_outputs();
      chk("rst_stall", stall, 1'b0);
      chk("rst_alg_op", alg_op, OP_NOP);
      chk("rst_opA", alg_opA, 16'd0);
      chk("rst_opB", alg_opB, 16'd0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_dest", wb_dest, 3'd0);
      chk("rst_wb_data", wb_data, 16'd0);
      chk("rst_hi", hi_reg, 16'd0);
      chk("rst_lo", lo_reg, 16'd0);
      chk("rst_ill", illegal_op, 1'b0);
      chk("rst_tmo", err_timeout, 1'b0);
   endtask

   // assert reset between clock edges, check asynchronously, release later
   task automatic reset_mid();
      @(negedge clk);
      issue_valid = 0; flush = 0; alg_done = 0;
      #3 reset = 1'b1;
      #1 check_reset_outputs();
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // one clock: drive, compare against the model, advance the model
   task automatic cycle(input bit iv, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] d, input bit fl);
      logic [31:0] prod;
      bit idle, acc, e_stall, done, ill_n, wb_hi_now;
      @(negedge clk);
      issue_valid = iv; issue_op = op; issue_a = a; issue_b = b;
      issue_dest = d; flush = fl;
      prod = 32'(alg_opA) * 32'(alg_opB);
      alg_hi = prod[31:16];
      alg_lo = prod[15:0];
      alg_done = (alg_op == OP_MUL) && !uhold && (ucnt == ulat - 1);
      #2;
      idle    = !m_inflight && (m_wb == 0);
      acc     = idle && iv && !fl && (op == OP_MUL);
      e_stall = acc || (m_inflight && !m_cancel) || (m_wb > 0) ||
                (m_inflight && m_cancel && iv && (op == OP_MUL));
      chk("stall", stall, e_stall);
      chk("alg_op", alg_op, m_aop);
      chk("alg_opA", alg_opA, m_a);
      chk("alg_opB", alg_opB, m_b);
      chk("wb_valid", wb_valid, m_wb > 0);
      chk("wb_dest", wb_dest, (m_wb == 2) ? m_dest : (m_wb == 1) ? 3'(m_dest + 3'd1) : 3'd0);
      chk("wb_data", wb_data, (m_wb == 2) ? m_lo : (m_wb == 1) ? m_hi : 16'd0);
      chk("hi_reg", hi_reg, m_hi);
      chk("lo_reg", lo_reg, m_lo);
      chk("illegal_op", illegal_op, m_ill);
      chk("err_timeout", err_timeout, m_tmo);
      if (stall) n_stall++;
      if (illegal_op) n_ill++;
      if (err_timeout) n_tmo++;
      if (wb_valid) begin
         log_dest.push_back(wb_dest);
         log_data.push_back(wb_data);
      end
      // advance the model
      done      = alg_done;
      wb_hi_now = (m_wb == 1);
      ill_n     = idle && iv && !fl && (op != OP_MUL);
      m_tmo     = 0;
      if (idle) begin
         if (acc) begin
            m_inflight = 1; m_cancel = 0; m_wait = 0;
            m_a = a; m_b = b; m_dest = d;
         end
      end else if (m_wb > 0) begin
         m_wb--;
      end else begin
         if (!m_cancel && fl) begin
            if (done) m_inflight = 0;
            else begin m_cancel = 1; m_wait = 0; end
         end else if (done) begin
            if (!m_cancel) begin
               m_hi = alg_hi; m_lo = alg_lo; m_wb = 2;
            end
            m_inflight = 0;
         end else if (m_wait + 1 == MAX_WAIT) begin
            m_inflight = 0; m_tmo = 1;
         end else begin
            m_wait++;
         end
      end
      m_aop = m_inflight ? OP_MUL : OP_NOP;
      m_ill = ill_n;
      retire = wb_hi_now || m_tmo || ill_n;
      // advance the unit
      if (alg_op == OP_MUL && !done) ucnt++;
      else begin
         ucnt = 0;
         if (urand) begin
            ulat  = $urandom_range(1, 10);
            uhold = ($urandom_range(0, 7) == 0);
         end
      end
   endtask

   // hold a multiply in EX until the pipeline would advance past it
   task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [2:0] d);
      bit got = 0;
      clear_obs();
      for (int i = 0; i < 30 && !got; i++) begin
         cycle(1, OP_MUL, a, b, d, 0);
         got = retire;
      end
      chk("mul_retired", got, 1'b1);
   endtask

   task automatic chk_writes(input string name, input logic [2:0] d0, input logic [15:0] v0,
                             input logic [2:0] d1, input logic [15:0] v1);
      chk({name, "_nwb"}, log_dest.size(), 2);
      if (log_dest.size() == 2) begin
         chk({name, "_d0"}, log_dest[0], d0);
         chk({name, "_v0"}, log_data[0], v0);
         chk({name, "_d1"}, log_dest[1], d1);
         chk({name, "_v1"}, log_data[1], v1);
      end
   endtask

   initial begin
      urand = 0;
      issue_valid = 0; issue_op = OP_NOP; issue_a = 0; issue_b = 0;
      issue_dest = 0; flush = 0; alg_done = 0; alg_hi = 0; alg_lo = 0;
      reset = 1'b1;
      #1 check_reset_outputs();
      model_reset();
      clear_obs();
      @(negedge clk);
      reset = 1'b0;

      // reset in the middle of a multiply
      cycle(1, OP_MUL, 16'h1234, 16'h0002, 3'd1, 0);
      cycle(1, OP_MUL, 16'h1234, 16'h0002, 3'd1, 0);
      cycle(1, OP_MUL, 16'h1234, 16'h0002, 3'd1, 0);
      reset_mid();
      run_mul(16'h0003, 16'h0005, 3'd2);
      chk_writes("after_reset", 3'd2, 16'h000F, 3'd3, 16'h0000);

      // plain multiply with stall length and committed registers
      run_mul(16'h0300, 16'h0200, 3'd3);
      chk("mul1_stall_cycles", n_stall, 7);
      chk_writes("mul1", 3'd3, 16'h0000, 3'd4, 16'h0006);
      chk("mul1_hi", hi_reg, 16'h0006);
      chk("mul1_lo", lo_reg, 16'h0000);

      // destination wrap
      run_mul(16'h00FF, 16'h0101, 3'd7);
      chk("wrap_stall_cycles", n_stall, 7);
      chk_writes("wrap", 3'd7, 16'hFFFF, 3'd0, 16'h0000);

      // flush on the second busy cycle, next multiply waits behind the drain
      cycle(1, OP_MUL, 16'h1111, 16'h2222, 3'd5, 0);
      cycle(1, OP_MUL, 16'h1111, 16'h2222, 3'd5, 0);
      cycle(1, OP_MUL, 16'h1111, 16'h2222, 3'd5, 1);
      chk("flush_hi_kept", hi_reg, 16'h0000);
      chk("flush_lo_kept", lo_reg, 16'hFFFF);
      run_mul(16'h0010, 16'h0010, 3'd1);
      chk("drain_stall_cycles", n_stall, 9);
      chk_writes("after_flush", 3'd1, 16'h0100, 3'd2, 16'h0000);
      chk("after_flush_lo", lo_reg, 16'h0100);

      // unsupported opcode
      clear_obs();
      cycle(1, 3'b101, 16'h0001, 16'h0001, 3'd0, 0);
      cycle(0, OP_NOP, 16'h0, 16'h0, 3'd0, 0);
      cycle(0, OP_NOP, 16'h0, 16'h0, 3'd0, 0);
      chk("illegal_pulses", n_ill, 1);
      chk("illegal_stall_cycles", n_stall, 0);
      chk("illegal_no_wb", log_dest.size(), 0);

      // unit never completes: watchdog
      uhold = 1;
      run_mul(16'h0007, 16'h0009, 3'd4);
      uhold = 0;
      chk("timeout_stall_cycles", n_stall, 1 + MAX_WAIT);
      cycle(0, OP_NOP, 16'h0, 16'h0, 3'd0, 0);
      cycle(0, OP_NOP, 16'h0, 16'h0, 3'd0, 0);
      chk("timeout_pulses", n_tmo, 1);
      chk("timeout_no_wb", log_dest.size(), 0);
      chk("timeout_lo_kept", lo_reg, 16'h0100);

      // randomized traffic, including variable unit latency and hangs
      urand = 1;
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 3) != 0),
               ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : OP_MUL,
               16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 15) == 0));
      end
      urand = 0;
      for (int i = 0; i < 20; i++) cycle(0, OP_NOP, 16'h0, 16'h0, 3'd0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
